// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (a - b - bin), LSB-first through one
// full-subtractor cell and a borrow flop, with valid/ready request and result channels.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o,
    output logic             ovf_o,
    output logic             busy_o
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-2:0] res_sr;
    logic             borrow;
    logic             a_msb;
    logic             b_msb;
    logic [CNT_W-1:0] cnt;
    logic             d_bit;
    logic             br_next;
    logic             req_fire;
    logic             last_bit;

    // Full-subtractor cell: returns {borrow_out, difference}.
    function automatic logic [1:0] full_sub(input logic a, input logic b, input logic br);
        logic d;
        logic bo;
        d  = a ^ b ^ br;
        bo = (~a & b) | (~(a ^ b) & br);
        return {bo, d};
    endfunction

    assign {br_next, d_bit} = full_sub(a_sr[0], b_sr[0], borrow);
    assign res_next         = {d_bit, res_sr};

    // Ready is held low while reset is asserted, not just in the IDLE state.
    assign req_ready_o = (state == IDLE) & reset_n_i;
    assign req_fire    = req_valid_i & req_ready_o;
    assign last_bit    = (cnt == LAST_BIT);
    assign rsp_valid_o = (state == DONE);
    assign busy_o      = (state != IDLE);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_fire) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    if (rsp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            borrow <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            cnt    <= '0;
            diff_o <= '0;
            bout_o <= 1'b0;
            ovf_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        a_sr   <= a_i;
                        b_sr   <= b_i;
                        res_sr <= '0;
                        borrow <= bin_i;
                        a_msb  <= a_i[WIDTH-1];
                        b_msb  <= b_i[WIDTH-1];
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    // Operands drain towards bit 0; vacated MSBs are zero-filled.
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    res_sr <= res_next[WIDTH-1:1];
                    borrow <= br_next;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        diff_o <= res_next;
                        bout_o <= br_next;
                        ovf_o  <= (a_msb != b_msb) & (d_bit != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int WIDTH = 8;
    localparam int NOPS  = 300;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             bin_in;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bo;
        logic             ov;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .a_i         (a_in),
        .b_i         (b_in),
        .bin_i       (bin_in),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .diff_o      (diff),
        .bout_o      (bout),
        .ovf_o       (ovf),
        .busy_o      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Reference: plain integer subtraction, borrow as unsigned compare, overflow from operand/result signs.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
        exp_t e;
        int ai;
        int bi;
        int di;
        ai   = int'(a);
        bi   = int'(b) + int'(bin);
        di   = ai - bi;
        e.d  = di[WIDTH-1:0];
        e.bo = (ai < bi);
        e.ov = (a[WIDTH-1] != b[WIDTH-1]) && (e.d[WIDTH-1] != a[WIDTH-1]);
        return e;
    endfunction

    // One request with rsp_ready high: checks latency, result, single-cycle valid and hold afterwards.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                          input logic [WIDTH-1:0] ed, input logic ebo, input logic eov);
        int lat;
        @(negedge clk);
        req_valid = 1'b1;
        a_in      = a;
        b_in      = b;
        bin_in    = bin;
        chk("op_req_ready", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat       = 0;
        while (!rsp_valid && lat < WIDTH + 4) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("op_latency", lat, WIDTH);
        chk("op_diff", diff, ed);
        chk("op_bout", bout, ebo);
        chk("op_ovf", ovf, eov);
        @(posedge clk);
        #1;
        chk("op_valid_pulse", rsp_valid, 0);
        chk("op_diff_held", diff, ed);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   pulses;
        int   cyc;
        int   last_acc;
        int   done;
        int   acc;
        int   lat;
        logic accept;

        reset_n   = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        a_in      = '0;
        b_in      = '0;
        bin_in    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_req_ready", req_ready, 1);

        run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

        // Backpressure: result held for 20 cycles while new requests are offered.
        e = model(8'h9C, 8'h31, 1'b0);
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        a_in      = 8'h9C;
        b_in      = 8'h31;
        bin_in    = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat       = 0;
        while (!rsp_valid && lat < WIDTH + 4) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp_latency", lat, WIDTH);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            a_in      = WIDTH'($urandom);
            b_in      = WIDTH'($urandom);
            bin_in    = 1'($urandom);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_diff", diff, e.d);
            chk("bp_ovf", ovf, e.ov);
            chk("bp_req_ready", req_ready, 0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_released", rsp_valid, 0);
        chk("bp_busy", busy, 0);
        chk("bp_diff_kept", diff, e.d);
        chk("bp_bout_kept", bout, e.bo);

        // Reset asserted mid-operation, at bit 4.
        @(negedge clk);
        req_valid = 1'b1;
        a_in      = 8'h55;
        b_in      = 8'h2A;
        bin_in    = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_diff", diff, 0);
        chk("abort_bout", bout, 0);
        chk("abort_ovf", ovf, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_req_ready", req_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        pulses  = 0;
        for (int i = 0; i < WIDTH + 3; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) pulses++;
        end
        chk("abort_no_pulse", pulses, 0);
        run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

        // Back-to-back random traffic with req_valid held high.
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        a_in      = WIDTH'($urandom);
        b_in      = WIDTH'($urandom);
        bin_in    = 1'($urandom);
        cyc       = 0;
        last_acc  = -1;
        done      = 0;
        acc       = 0;
        while (done < NOPS && cyc < NOPS * 14 + 50) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                chk("b2b_sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("b2b_diff", diff, e.d);
                    chk("b2b_bout", bout, e.bo);
                    chk("b2b_ovf", ovf, e.ov);
                end
                done++;
            end
            accept = req_valid & req_ready;
            if (accept) begin
                exp_q.push_back(model(a_in, b_in, bin_in));
                if (last_acc >= 0) chk("b2b_gap", (cyc - last_acc) >= WIDTH + 1, 1);
                last_acc = cyc;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (accept) begin
                acc++;
                if (acc >= NOPS) req_valid = 1'b0;
                a_in   = WIDTH'($urandom);
                b_in   = WIDTH'($urandom);
                bin_in = 1'($urandom);
            end
        end
        req_valid = 1'b0;
        chk("b2b_done", done, NOPS);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
